uart_transmitter_apb: RTL and testbench

//  APB-slave UART transmitter; the upstream stage of the APB UART receiver.
//  One APB write of a 32-bit word sends one serial frame on o_tx_serial:

---
 rtl/uart_apb_pkg.sv | 30 +++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_transmitter_apb.sv | 153 +++++++++++++++
 tb/tb_uart_transmitter_apb.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_apb_pkg.sv
// Shared definitions for the APB UART transmitter/receiver pair: APB and TX
// state codes, payload width and serial line levels.
package uart_apb_pkg;

    localparam int DATA_W = 32;

    localparam logic IDLE_LEVEL  = 1'b0;
    localparam logic START_LEVEL = 1'b1;
    localparam logic STOP_LEVEL  = 1'b1;

    // Codes are shared with the receiver, so they are pinned explicitly.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10
    } apb_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: tick marks the last pclk cycle of each serial bit.
// Held at zero while clr is high so the first bit after clr is full length.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic pclk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            TW   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clr || tick)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_transmitter_apb.sv
// APB slave that sends each accepted 32-bit write as one serial frame:
// start, 32 data bits LSB first, parity, stop. pready is withheld until the frame is out.
module uart_transmitter_apb
    import uart_apb_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 1,
    parameter logic [31:0] TX_ADDR      = 32'h0
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [31:0]       padd,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic              pslverr,
    output logic              o_tx_serial,
    output logic              o_tx_active,
    output logic              o_tx_done
);

    apb_state_t        apb_state, apb_nxt;
    tx_state_t         tx_state, tx_nxt;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] shreg;
    logic              parity_q;
    logic [4:0]        bit_idx;
    logic              abort_q, abort_nxt;
    logic              pready_nxt, pslverr_nxt, done_nxt;
    logic              tick, addr_ok, latch_en, shift_en;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
        .pclk (pclk),
        .rst  (rst),
        .clr  (tx_state == TX_IDLE),
        .tick (tick)
    );

    assign addr_ok  = (addr_q == TX_ADDR);
    assign latch_en = (apb_state == IDLE) && psel && !penable && pwrite;
    assign shift_en = (apb_state == ACCESS) && (tx_state == TX_DATA) && tick;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            apb_state <= IDLE;
            tx_state  <= TX_IDLE;
            abort_q   <= 1'b0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            o_tx_done <= 1'b0;
        end else begin
            apb_state <= apb_nxt;
            tx_state  <= tx_nxt;
            abort_q   <= abort_nxt;
            pready    <= pready_nxt;
            pslverr   <= pslverr_nxt;
            o_tx_done <= done_nxt;
        end
    end

    always_comb begin
        apb_nxt     = apb_state;
        tx_nxt      = tx_state;
        abort_nxt   = abort_q;
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;
        done_nxt    = 1'b0;
        case (apb_state)
            IDLE: begin
                abort_nxt = 1'b0;
                if (psel && !penable) begin
                    if (pwrite) begin
                        apb_nxt = SETUP;
                    end else begin
                        apb_nxt     = ACCESS;
                        pready_nxt  = 1'b1;
                        pslverr_nxt = 1'b1;
                    end
                end
            end
            SETUP: begin
                apb_nxt = ACCESS;
                if (addr_ok) begin
                    tx_nxt = TX_START;
                end else begin
                    pready_nxt  = 1'b1;
                    pslverr_nxt = 1'b1;
                end
            end
            ACCESS: begin
                if (pready || tx_state == TX_IDLE) begin
                    apb_nxt = IDLE;
                end else begin
                    // A dropped select/enable is remembered until the current bit ends.
                    if (!psel || !penable)
                        abort_nxt = 1'b1;
                    if (tick) begin
                        if (abort_nxt) begin
                            tx_nxt      = TX_IDLE;
                            pready_nxt  = 1'b1;
                            pslverr_nxt = 1'b1;
                        end else begin
                            case (tx_state)
                                TX_START:  tx_nxt = TX_DATA;
                                TX_DATA:   if (bit_idx == 5'd31) tx_nxt = TX_PARITY;
                                TX_PARITY: tx_nxt = TX_STOP;
                                TX_STOP: begin
                                    tx_nxt     = TX_IDLE;
                                    pready_nxt = 1'b1;
                                    done_nxt   = 1'b1;
                                end
                                default:   tx_nxt = TX_IDLE;
                            endcase
                        end
                    end
                end
            end
            default: apb_nxt = IDLE;
        endcase
    end

    // Payload and parity are captured once at setup; later pwdata changes are ignored.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            shreg    <= '0;
            parity_q <= 1'b0;
            bit_idx  <= '0;
        end else if (latch_en) begin
            addr_q   <= padd;
            shreg    <= pwdata;
            parity_q <= even_parity(pwdata);
            bit_idx  <= '0;
        end else if (shift_en) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 5'd1;
        end
    end

    always_comb begin
        case (tx_state)
            TX_START:  o_tx_serial = START_LEVEL;
            TX_DATA:   o_tx_serial = shreg[0];
            TX_PARITY: o_tx_serial = parity_q;
            TX_STOP:   o_tx_serial = STOP_LEVEL;
            default:   o_tx_serial = IDLE_LEVEL;
        endcase
    end

    assign o_tx_active = (tx_state != TX_IDLE);

endmodule

// File: tb/tb_uart_transmitter_apb.sv
// Directed bench for uart_transmitter_apb at CLKS_PER_BIT=1 and 8, with a
// bench-side frame decoder standing in for the receiver.
module tb_uart_transmitter_apb;

    logic        pclk = 1'b0;
    logic        rst  = 1'b1;
    logic        psel1 = 1'b0, psel8 = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] padd = 32'h0, pwdata = 32'h0;
    logic        pready1, pslverr1, ser1, act1, done1;
    logic        pready8, pslverr8, ser8, act8, done8;

    int total = 0;
    int bad   = 0;

    logic [511:0] line;
    int           ready_cyc;
    logic         err_at_ready, done_at_ready, act_first;

    always #5 pclk = ~pclk;

    uart_transmitter_apb #(.CLKS_PER_BIT(1), .TX_ADDR(32'h0)) dut1 (
        .pclk(pclk), .rst(rst), .psel(psel1), .penable(penable), .pwrite(pwrite),
        .padd(padd), .pwdata(pwdata), .pready(pready1), .pslverr(pslverr1),
        .o_tx_serial(ser1), .o_tx_active(act1), .o_tx_done(done1)
    );

    uart_transmitter_apb #(.CLKS_PER_BIT(8), .TX_ADDR(32'h0)) dut8 (
        .pclk(pclk), .rst(rst), .psel(psel8), .penable(penable), .pwrite(pwrite),
        .padd(padd), .pwdata(pwdata), .pready(pready8), .pslverr(pslverr8),
        .o_tx_serial(ser8), .o_tx_active(act8), .o_tx_done(done8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One APB write; records the line per cycle, cycle 1 = first cycle after SETUP.
    task automatic apb_write(input bit big, input logic [31:0] addr, input logic [31:0] data);
        @(posedge pclk); #1;
        psel1 = !big; psel8 = big; pwrite = 1'b1; penable = 1'b0;
        padd = addr; pwdata = data;
        @(posedge pclk); #1;
        penable = 1'b1;
        pwdata  = ~data;
        line = '0; ready_cyc = -1; err_at_ready = 1'b0; done_at_ready = 1'b0; act_first = 1'b0;
        for (int k = 1; k < 400; k++) begin
            @(posedge pclk); @(negedge pclk);
            line[k] = big ? ser8 : ser1;
            if (k == 1) act_first = big ? act8 : act1;
            if (big ? pready8 : pready1) begin
                ready_cyc     = k;
                err_at_ready  = big ? pslverr8 : pslverr1;
                done_at_ready = big ? done8 : done1;
                break;
            end
        end
        @(posedge pclk); #1;
        psel1 = 1'b0; psel8 = 1'b0; penable = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int c, input logic [31:0] data);
        int          mism;
        logic [31:0] dec;
        mism = 0;
        for (int k = 1; k <= 35 * c + 1; k++) begin
            int   b;
            logic e;
            b = (k - 1) / c;
            if (b == 0)       e = 1'b1;
            else if (b <= 32) e = data[b-1];
            else if (b == 33) e = ^data;
            else if (b == 34) e = 1'b1;
            else              e = 1'b0;
            if (line[k] !== e) mism++;
        end
        for (int i = 0; i < 32; i++)
            dec[i] = line[1 + (i + 1) * c + c / 2];
        check({tag, ".frame_mism"}, 64'(mism), 64'd0);
        check({tag, ".payload"}, 64'(dec), 64'(data));
    endtask

    initial begin
        int pulses;

        #1;
        check("reset.dut1", 64'({ser1, pready1, pslverr1, act1, done1}), 64'd0);
        check("reset.dut8", 64'({ser8, pready8, pslverr8, act8, done8}), 64'd0);
        repeat (3) @(posedge pclk);
        #1 rst = 1'b0;

        // Single set bit: start, 1, zeros, parity 1, stop, idle.
        apb_write(1'b0, 32'h0, 32'h0000_0001);
        check("t1.ready_cyc", 64'(ready_cyc), 64'd36);
        check("t1.err_done_act", 64'({err_at_ready, done_at_ready, act_first}), 64'b011);
        check("t1.bits", 64'({line[1], line[2], line[3], line[33], line[34], line[35], line[36]}),
              64'b1100110);
        check_frame("t1", 1, 32'h0000_0001);

        apb_write(1'b0, 32'h0, 32'hA5A5_A5A5);
        check("t2.ready_cyc", 64'(ready_cyc), 64'd36);
        check("t2.lsb_first", 64'({line[2], line[3], line[4], line[5], line[6], line[7], line[8], line[9]}),
              64'b10100101);
        check("t2.parity", 64'(line[34]), 64'd0);
        check_frame("t2", 1, 32'hA5A5_A5A5);

        apb_write(1'b0, 32'h4, 32'hFFFF_FFFF);
        check("t3.ready_cyc", 64'(ready_cyc), 64'd1);
        check("t3.err_done", 64'({err_at_ready, done_at_ready}), 64'b10);
        check("t3.line", 64'({line[1], ser1, act1}), 64'd0);

        // Read is rejected in the first access cycle.
        @(posedge pclk); #1;
        psel1 = 1'b1; pwrite = 1'b0; penable = 1'b0; padd = 32'h0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("rd.resp", 64'({pready1, pslverr1, ser1, act1}), 64'b1100);
        @(posedge pclk); #1;
        psel1 = 1'b0; penable = 1'b0;

        apb_write(1'b0, 32'h0, 32'hDEAD_BEEF);
        check("t4.ready_err", 64'({ready_cyc[7:0], err_at_ready}), 64'({8'd36, 1'b0}));
        check("t4.parity", 64'(line[34]), 64'd0);
        check_frame("t4", 1, 32'hDEAD_BEEF);

        apb_write(1'b0, 32'h0, 32'h1234_5678);
        check("b2b.ready_cyc", 64'(ready_cyc), 64'd36);
        check_frame("b2b", 1, 32'h1234_5678);

        apb_write(1'b1, 32'h0, 32'hFFFF_FFFF);
        check("t5.ready_cyc", 64'(ready_cyc), 64'd281);
        check("t5.err_done_act", 64'({err_at_ready, done_at_ready, act_first}), 64'b011);
        check("t5.tail", 64'({line[264], line[265], line[272], line[273], line[280], line[281]}),
              64'b100110);
        check_frame("t5", 8, 32'hFFFF_FFFF);

        // Protocol abort: select dropped during data bit 3.
        @(posedge pclk); #1;
        psel1 = 1'b1; pwrite = 1'b1; penable = 1'b0; padd = 32'h0; pwdata = 32'h0F0F_0F0F;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (5) @(posedge pclk);
        #1;
        psel1 = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("abort.pre", 64'(pready1), 64'd0);
        @(posedge pclk); @(negedge pclk);
        check("abort.resp", 64'({pready1, pslverr1, ser1, act1, done1}), 64'b11000);

        // Reset during data bit 10 (cycle 12).
        @(posedge pclk); #1;
        psel1 = 1'b1; pwrite = 1'b1; penable = 1'b0; padd = 32'h0; pwdata = 32'hFFFF_FFFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (12) @(posedge pclk);
        #1;
        check("t6.bit10", 64'({ser1, act1}), 64'b11);
        rst = 1'b1;
        #1;
        check("t6.line_drop", 64'({ser1, act1, pready1}), 64'd0);
        @(posedge pclk); #1;
        rst = 1'b0; psel1 = 1'b0; penable = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge pclk);
            if (pready1 || ser1) pulses++;
        end
        check("t6.no_pready", 64'(pulses), 64'd0);
        apb_write(1'b0, 32'h0, 32'hCAFE_F00D);
        check("t6.ready_cyc", 64'(ready_cyc), 64'd36);
        check_frame("t6", 1, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
